// File: rtl/reset_sequencer.sv
// Reset sequencer: filters a command strobe, then drives CHANNELS synchronous resets
// that are held together for STRETCH cycles and released in ascending order, STAGGER apart.
module reset_sequencer #(
  parameter int CHANNELS = 3,
  parameter int STRETCH  = 8,
  parameter int STAGGER  = 4,
  parameter int FILTER   = 2,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cmd_strobe,
  output logic [CHANNELS-1:0] reset_out,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    seq_count
);

  localparam int STRETCH_W = $clog2(STRETCH + 1);
  localparam int FILT_W    = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam int REL_MAX   = (CHANNELS - 1) * STAGGER;
  localparam int REL_W     = (REL_MAX > 0) ? $clog2(REL_MAX + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    RELEASE
  } state_t;

  state_t                 state_q, state_d;
  logic [STRETCH_W-1:0]   stretch_q, stretch_d;
  logic [FILT_W-1:0]      filt_q, filt_d;
  logic [REL_W-1:0]       rel_q, rel_d;
  logic [CHANNELS-1:0]    reset_out_q, reset_out_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       seq_count_q, seq_count_d;

  logic                   qualify;
  logic [CHANNELS-1:0]    rel_mask;
  int                     elapsed;

  // Channels already released after 'elapsed' cycles of the release phase.
  function automatic logic [CHANNELS-1:0] release_mask(input int cycles);
    logic [CHANNELS-1:0] m;
    m = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cycles >= k * STAGGER) m[k] = 1'b1;
    end
    return m;
  endfunction

  always_comb begin
    qualify = cmd_strobe && (filt_q == FILT_W'(FILTER - 1));
    filt_d  = (cmd_strobe && !qualify) ? filt_q + FILT_W'(1) : '0;
  end

  always_comb begin
    state_d     = state_q;
    stretch_d   = stretch_q;
    rel_d       = rel_q;
    reset_out_d = reset_out_q;
    done_d      = 1'b0;
    seq_count_d = seq_count_q;
    rel_mask    = '0;
    elapsed     = 0;

    if (qualify) begin
      // The qualifying edge is itself the first asserted cycle, hence STRETCH-1.
      state_d     = ASSERT;
      stretch_d   = STRETCH_W'(STRETCH - 1);
      rel_d       = '0;
      reset_out_d = '1;
      if (seq_count_q != {CNT_W{1'b1}}) seq_count_d = seq_count_q + CNT_W'(1);
    end else begin
      case (state_q)
        IDLE: begin
          reset_out_d = '0;
        end
        ASSERT: begin
          if (stretch_q == '0) begin
            elapsed     = 0;
            rel_mask    = release_mask(elapsed);
            reset_out_d = ~rel_mask;
            rel_d       = '0;
            if (&rel_mask) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            stretch_d = stretch_q - STRETCH_W'(1);
          end
        end
        RELEASE: begin
          elapsed     = int'(rel_q) + 1;
          rel_mask    = release_mask(elapsed);
          reset_out_d = ~rel_mask;
          rel_d       = REL_W'(elapsed);
          if (&rel_mask) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d     = IDLE;
          reset_out_d = '0;
        end
      endcase
    end

    busy_d = |reset_out_d;
  end

  // Reset parks the block in ASSERT so leaving reset runs a full power-on sequence.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ASSERT;
      stretch_q   <= STRETCH_W'(STRETCH);
      filt_q      <= '0;
      rel_q       <= '0;
      reset_out_q <= '1;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      seq_count_q <= '0;
    end else begin
      state_q     <= state_d;
      stretch_q   <= stretch_d;
      filt_q      <= filt_d;
      rel_q       <= rel_d;
      reset_out_q <= reset_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      seq_count_q <= seq_count_d;
    end
  end

  assign reset_out = reset_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign seq_count = seq_count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a default instance and a CNT_W=2/STAGGER=0 instance
// share one stimulus stream and are checked against an age-based reference model.
module tb_reset_sequencer;

  localparam int CH   = 3;
  localparam int ST   = 8;
  localparam int FL   = 2;
  localparam int SG_A = 4;
  localparam int CW_A = 8;
  localparam int SG_B = 0;
  localparam int CW_B = 2;

  logic            clk = 1'b0;
  logic            resetn;
  logic            cmd_strobe;
  logic [CH-1:0]   ro_a, ro_b;
  logic            busy_a, busy_b, done_a, done_b;
  logic [CW_A-1:0] cnt_a;
  logic [CW_B-1:0] cnt_b;

  typedef struct packed {
    int active;
    int age;
    int run;
    int count;
    int done;
  } model_t;

  typedef struct packed {
    logic [7:0] ro;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
  } exp_t;

  exp_t   q_a[$];
  exp_t   q_b[$];
  model_t m_a = '0;
  model_t m_b = '0;
  int     checks = 0;
  int     errors = 0;

  always #5 clk = ~clk;

  reset_sequencer #(.CHANNELS(CH), .STRETCH(ST), .STAGGER(SG_A), .FILTER(FL), .CNT_W(CW_A)) dut_a (
    .clk(clk), .resetn(resetn), .cmd_strobe(cmd_strobe),
    .reset_out(ro_a), .busy(busy_a), .done(done_a), .seq_count(cnt_a)
  );

  reset_sequencer #(.CHANNELS(CH), .STRETCH(ST), .STAGGER(SG_B), .FILTER(FL), .CNT_W(CW_B)) dut_b (
    .clk(clk), .resetn(resetn), .cmd_strobe(cmd_strobe),
    .reset_out(ro_b), .busy(busy_b), .done(done_b), .seq_count(cnt_b)
  );

  // Age counts cycles since the sequence's assertion edge; reset parks it at -1.
  function automatic model_t model_step(model_t m, int sg, int cw, logic cmd, logic rstn);
    model_t n;
    n = m;
    if (!rstn) begin
      n.active = 1; n.age = -1; n.run = 0; n.count = 0; n.done = 0;
      return n;
    end
    n.done = 0;
    n.run  = cmd ? m.run + 1 : 0;
    if (n.run == FL) begin
      n.run    = 0;
      n.active = 1;
      n.age    = 0;
      if (n.count < (1 << cw) - 1) n.count = n.count + 1;
    end else if (m.active != 0) begin
      n.age = m.age + 1;
      if (n.age == ST + (CH - 1) * sg) begin
        n.done   = 1;
        n.active = 0;
      end
    end
    return n;
  endfunction

  function automatic exp_t expect_of(model_t m, int sg);
    exp_t e;
    e = '0;
    for (int k = 0; k < CH; k++)
      e.ro[k] = (m.active != 0) && (m.age < ST + k * sg);
    e.busy = |e.ro;
    e.done = (m.done != 0);
    e.cnt  = 8'(m.count);
    return e;
  endfunction

  task automatic applyStimulus(input logic c, input logic r);
    cmd_strobe = c;
    resetn     = r;
    m_a = model_step(m_a, SG_A, CW_A, c, r);
    m_b = model_step(m_b, SG_B, CW_B, c, r);
    q_a.push_back(expect_of(m_a, SG_A));
    q_b.push_back(expect_of(m_b, SG_B));
    @(posedge clk);
    #3;
  endtask

  task automatic checkOutput(input string name, input exp_t e, input exp_t act);
    checks++;
    if (act !== e) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got reset_out=%b busy=%b done=%b seq_count=%0d, want reset_out=%b busy=%b done=%b seq_count=%0d",
               name, $time, act.ro, act.busy, act.done, act.cnt, e.ro, e.busy, e.done, e.cnt);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b1);
  endtask

  // Monitor: pops one expectation per cycle and compares away from the clock edge.
  initial begin
    exp_t act;
    forever begin
      @(posedge clk);
      #2;
      if (q_a.size() > 0) begin
        act = '0;
        act.ro = 8'(ro_a); act.busy = busy_a; act.done = done_a; act.cnt = 8'(cnt_a);
        checkOutput("seq_a", q_a.pop_front(), act);
      end
      if (q_b.size() > 0) begin
        act = '0;
        act.ro = 8'(ro_b); act.busy = busy_b; act.done = done_b; act.cnt = 8'(cnt_b);
        checkOutput("seq_b", q_b.pop_front(), act);
      end
    end
  end

  initial begin
    int p;
    int len;

    repeat (3) applyStimulus(1'b0, 1'b0);
    idle(30);

    applyStimulus(1'b1, 1'b1);
    idle(8);

    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    idle(7);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    idle(30);

    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    idle(10);
    applyStimulus(1'b0, 1'b0);
    idle(30);

    repeat (5) begin
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1);
      idle(25);
    end

    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    idle(15);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    idle(25);

    for (int seg = 0; seg < 60; seg++) begin
      p   = $urandom_range(0, 70);
      len = $urandom_range(10, 60);
      for (int i = 0; i < len; i++)
        applyStimulus(($urandom_range(0, 99) < p), ($urandom_range(0, 199) != 0));
    end
    idle(30);

    for (int i = 0; i < 20 && (q_a.size() > 0 || q_b.size() > 0); i++) @(posedge clk);
    #3;
    if (q_a.size() > 0 || q_b.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d/%0d expectations left, want 0/0", q_a.size(), q_b.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
